// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding, bus word and arbiter FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache; dcache has priority
// unless icache has been starved for STARVE_LIMIT consecutive dcache grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    // icache side
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    // dcache side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    // RAM side
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic [2:0] r_dstreak;
    logic [2:0] w_dstreak_next;

    logic w_dreq;
    logic w_access;
    logic w_in_gi;
    logic w_in_gd;
    logic w_starved;

    assign w_dreq    = dREN | dWEN;
    assign w_access  = (ramstate_t'(ramstate) == ACCESS);
    assign w_starved = (r_dstreak == 3'(STARVE_LIMIT));

    // Reset gates the grant view so the RAM is never driven while RST is high,
    // even in the cycle where a grant is being abandoned.
    assign w_in_gi = (r_state == GNT_I) && !RST;
    assign w_in_gd = (r_state == GNT_D) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
        end else begin
            r_state   <= w_next;
            r_dstreak <= w_dstreak_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_dstreak_next = r_dstreak;
        case (r_state)
            IDLE: begin
                if (w_dreq && iREN && w_starved) begin
                    w_next         = GNT_I;
                    w_dstreak_next = '0;
                end else if (w_dreq) begin
                    w_next = GNT_D;
                    if (iREN) begin
                        w_dstreak_next = (r_dstreak == 3'b111) ? r_dstreak : r_dstreak + 3'd1;
                    end else begin
                        w_dstreak_next = '0;
                    end
                end else if (iREN) begin
                    w_next         = GNT_I;
                    w_dstreak_next = '0;
                end
            end
            GNT_I: begin
                if (!iREN || w_access) begin
                    w_next = IDLE;
                end
            end
            GNT_D: begin
                if (!w_dreq || w_access) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        if (w_in_gi) begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (w_access) begin
                iload = ramload;
            end
        end
        if (w_in_gd) begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (w_access) begin
                dload = ramload;
            end
        end
        iwait = iREN & ~(w_in_gi & w_access);
        dwait = w_dreq & ~(w_in_gd & w_access);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    initial begin
        RST      = 1'b1;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = 2'(FREE);
        cyc();
        cyc();
        settle();
        check("rst_ramREN",   ramREN, 0);
        check("rst_ramWEN",   ramWEN, 0);
        check("rst_ramaddr",  ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_iload",    iload, 0);
        check("rst_dload",    dload, 0);
        check("rst_iwait",    iwait, 0);
        check("rst_dwait",    dwait, 0);
        check("rst_state",    dut.r_state, IDLE);
        check("rst_dstreak",  dut.r_dstreak, 0);
        RST = 1'b0;
        cyc();

        // Single icache read, ACCESS on the 2nd GNT_I cycle
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'(FREE);
        settle();
        check("ird_idle_ramREN", ramREN, 0);
        check("ird_idle_iwait",  iwait, 1);
        cyc();
        ramstate = 2'(BUSY);
        settle();
        check("ird_c1_state",   dut.r_state, GNT_I);
        check("ird_c1_ramREN",  ramREN, 1);
        check("ird_c1_ramaddr", ramaddr, 32'h40);
        check("ird_c1_iwait",   iwait, 1);
        check("ird_c1_iload",   iload, 0);
        cyc();
        ramstate = 2'(ACCESS); ramload = 32'hDEADBEEF;
        settle();
        check("ird_c2_ramREN",   ramREN, 1);
        check("ird_c2_ramaddr",  ramaddr, 32'h40);
        check("ird_c2_ramWEN",   ramWEN, 0);
        check("ird_c2_ramstore", ramstore, 0);
        check("ird_c2_iwait",    iwait, 0);
        check("ird_c2_iload",    iload, 32'hDEADBEEF);
        cyc();
        iREN = 1'b0; ramstate = 2'(FREE);
        settle();
        check("ird_done_state", dut.r_state, IDLE);
        check("ird_done_iload", iload, 0);
        check("ird_dstreak",    dut.r_dstreak, 0);

        // Simultaneous requests with dstreak=0: dcache first, icache next
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
        cyc();
        settle();
        check("sim_d_state",   dut.r_state, GNT_D);
        check("sim_d_ramaddr", ramaddr, 32'h200);
        check("sim_d_ramREN",  ramREN, 1);
        check("sim_d_iwait",   iwait, 1);
        check("sim_d_dwait",   dwait, 1);
        check("sim_d_dstreak", dut.r_dstreak, 1);
        ramstate = 2'(ACCESS); ramload = 32'hCAFE0001;
        settle();
        check("sim_d_dwait_done", dwait, 0);
        check("sim_d_dload",      dload, 32'hCAFE0001);
        check("sim_d_iload",      iload, 0);
        cyc();
        dREN = 1'b0; ramstate = 2'(FREE);
        settle();
        check("sim_idle_state",  dut.r_state, IDLE);
        check("sim_idle_ramREN", ramREN, 0);
        cyc();
        settle();
        check("sim_i_state",   dut.r_state, GNT_I);
        check("sim_i_ramaddr", ramaddr, 32'h80);
        check("sim_i_dstreak", dut.r_dstreak, 0);
        ramstate = 2'(ACCESS); ramload = 32'h11;
        settle();
        check("sim_i_iload", iload, 32'h11);
        check("sim_i_iwait", iwait, 0);
        cyc();
        iREN = 1'b0; ramstate = 2'(FREE);

        // Starvation: four 1-cycle dcache grants, then icache wins
        iREN = 1'b1; dREN = 1'b1; ramstate = 2'(ACCESS);
        for (int k = 0; k < 4; k++) begin
            cyc();
            settle();
            check($sformatf("stv_gnt%0d_state", k), dut.r_state, GNT_D);
            cyc();
            settle();
            check($sformatf("stv_idle%0d_state", k), dut.r_state, IDLE);
        end
        check("stv_dstreak_max", dut.r_dstreak, 4);
        cyc();
        settle();
        check("stv_i_state",   dut.r_state, GNT_I);
        check("stv_i_dstreak", dut.r_dstreak, 0);
        iREN = 1'b0; dREN = 1'b0;
        cyc();
        ramstate = 2'(BUSY);

        // Write wins, then reset mid-grant
        iREN = 1'b1; iaddr = 32'h44;
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678;
        cyc();
        settle();
        check("wr_state",    dut.r_state, GNT_D);
        check("wr_ramWEN",   ramWEN, 1);
        check("wr_ramREN",   ramREN, 0);
        check("wr_ramstore", ramstore, 32'h12345678);
        check("wr_ramaddr",  ramaddr, 32'h100);
        check("wr_dstreak",  dut.r_dstreak, 1);
        RST = 1'b1;
        settle();
        check("rstg_during_ramWEN", ramWEN, 0);
        cyc();
        settle();
        check("rstg_state",   dut.r_state, IDLE);
        check("rstg_ramWEN",  ramWEN, 0);
        check("rstg_ramREN",  ramREN, 0);
        check("rstg_dstreak", dut.r_dstreak, 0);
        RST = 1'b0;
        cyc();
        settle();
        check("rstg_rearb_state", dut.r_state, GNT_D);
        ramstate = 2'(ACCESS);
        cyc();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'(FREE);
        cyc();

        // ERROR retried for 3 cycles, then icache drops its request
        iREN = 1'b1; iaddr = 32'h44; ramstate = 2'(ERROR);
        cyc();
        for (int k = 0; k < 3; k++) begin
            settle();
            check($sformatf("err%0d_ramREN", k),  ramREN, 1);
            check($sformatf("err%0d_ramaddr", k), ramaddr, 32'h44);
            check($sformatf("err%0d_iwait", k),   iwait, 1);
            cyc();
        end
        iREN = 1'b0;
        settle();
        check("abort_state",  dut.r_state, GNT_I);
        check("abort_ramREN", ramREN, 0);
        check("abort_ramWEN", ramWEN, 0);
        cyc();
        settle();
        check("abort_idle_state", dut.r_state, IDLE);
        check("abort_iload",      iload, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
